pdp_mem_arbiter: RTL
====================

PDP_MEM_ARBITER -- requirements
Module: pdp_mem_arbiter

Interface
REQ-001 The block SHALL have parameter ADDR_WIDTH, default 12, giving the PDP-8 word address width.
REQ-002 The block SHALL have parameter DATA_WIDTH, default 12, giving the PDP-8 word width.
REQ-003 The block SHALL have parameter TIMEOUT_CYCLES, default 16, giving the watchdog limit for one memory access.
REQ-004 Port clk: input, 1 bit, the single clock; all state changes on its rising edge.
REQ-005 Port reset: input, 1 bit, synchronous, active-high reset.
REQ-006 Port ifd_req: input, 1 bit, fetch-read request from the IFD; level, held until ifd_done.
REQ-007 Port ifd_addr: input, ADDR_WIDTH bits, fetch address.
REQ-008 Port ifd_done: output, 1 bit, one-cycle completion pulse to the IFD.
REQ-009 Port ifd_rdata: output, DATA_WIDTH bits, fetched word, valid while ifd_done is high.
REQ-010 Port ex_req: input, 1 bit, execute-unit access request; level, held until ex_done.
REQ-011 Port ex_we: input, 1 bit, 1 = write, 0 = read.
REQ-012 Port ex_addr: input, ADDR_WIDTH bits, execute access address.
REQ-013 Port ex_wdata: input, DATA_WIDTH bits, execute write data.
REQ-014 Port ex_done: output, 1 bit, one-cycle completion pulse to the execute unit.
REQ-015 Port ex_rdata: output, DATA_WIDTH bits, read word, valid while ex_done is high after a read.
REQ-016 Port mem_valid: output, 1 bit, shared memory-port access strobe.
REQ-017 Ports mem_we (1 bit), mem_addr (ADDR_WIDTH bits) and mem_wdata (DATA_WIDTH bits): outputs, access type, address and write data.
REQ-018 Port mem_ready: input, 1 bit, memory completes the access in the cycle it is sampled high.
REQ-019 Port mem_rdata: input, DATA_WIDTH bits, read data, valid with mem_ready.
REQ-020 Port err: output, 1 bit, one-cycle pulse, coincident with done, flagging a timed-out access.

Function
REQ-021 The FSM SHALL have exactly four states: IDLE, IFD_ACC, EX_ACC, RESP.
REQ-022 In IDLE with exactly one request high, the FSM SHALL move to that requester's ACC state on the next edge and latch its address, we and wdata; ifd_* accesses always use we=0.
REQ-023 In IDLE with both requests high, the FSM SHALL grant the requester not granted last (round-robin) and update last_grant.
REQ-024 mem_valid SHALL be 1 only in IFD_ACC and EX_ACC, and mem_addr/mem_we/mem_wdata SHALL be driven from latched values, stable for the whole access.
REQ-025 In an ACC state with mem_ready=1, the FSM SHALL capture mem_rdata (reads only) into the granted requester's rdata register and move to RESP.
REQ-026 In RESP, the granted requester's done SHALL be 1 for exactly one cycle, and the FSM SHALL return to IDLE unconditionally.
REQ-027 A request still high in the IDLE cycle after RESP SHALL be treated as a new request, so requesters drop req in the cycle their done is high.
REQ-028 Minimum latency SHALL be 2 cycles from the first edge sampling req to done (IDLE -> ACC with mem_ready=1 -> RESP).
REQ-029 On a write, ex_rdata SHALL keep its previous value, and ifd_rdata SHALL change only on IFD reads.
REQ-030 Changes to a non-granted requester's inputs SHALL NOT affect the current access.
REQ-031 mem_ready while in IDLE or RESP SHALL be ignored.

Reset
REQ-032 When reset=1 at an edge, the block SHALL enter IDLE, set last_grant=EX (so the first tie goes to IFD), and clear the watchdog.
REQ-033 Reset values SHALL be: mem_valid=0, mem_we=0, mem_addr=0, mem_wdata=0, ifd_done=0, ex_done=0, err=0, ifd_rdata=0, ex_rdata=0.
REQ-034 Reset during an ACC or RESP state SHALL abort the access with no done pulse.

Configuration
REQ-035 Macro PDP_MEM_ARB_TIMEOUT_EN, when defined, SHALL enable a watchdog counter that clears on ACC entry and counts each ACC cycle with mem_ready=0.
REQ-036 With the macro defined, reaching TIMEOUT_CYCLES SHALL force RESP, pulse done and err together, and leave rdata unchanged.
REQ-037 Without the macro, the block SHALL have no counter, err SHALL be tied 0, and ACC SHALL wait indefinitely for mem_ready.

Verification
REQ-038 Reset, then ifd_req=1, ifd_addr=0o200, mem_ready=1 on the first mem_valid cycle, mem_rdata=0o7300 -> mem_addr=0o200, mem_we=0, ifd_done pulse 2 cycles after req, ifd_rdata=0o7300.
REQ-039 ex_req=1, ex_we=1, ex_addr=0o10, ex_wdata=0o1234, mem_ready delayed 3 cycles -> mem_valid high 4 cycles, mem_wdata=0o1234, ex_done single pulse, ex_rdata unchanged.
REQ-040 Both requests held continuously from reset, with mem_ready=1 every cycle -> grant order IFD, EX, IFD, EX, with no two consecutive grants to one requester.
REQ-041 Reset asserted in the second EX_ACC cycle -> mem_valid=0 after that edge, no ex_done, and the next tie is granted to IFD.
REQ-042 With PDP_MEM_ARB_TIMEOUT_EN defined and mem_ready held 0 -> ifd_done and err pulse together after 16 ACC cycles; without the macro -> mem_valid stays high and err stays 0.

Source files
------------

// File: rtl/pdp_mem_arbiter.sv
// PDP-8 shared memory-port arbiter: round-robin between the fetch unit (IFD) and the execute unit (EX).
// Define PDP_MEM_ARB_TIMEOUT_EN to enable the per-access watchdog; otherwise err is tied low.
module pdp_mem_arbiter #(
  parameter int ADDR_WIDTH     = 12,
  parameter int DATA_WIDTH     = 12,
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  ifd_req,
  input  logic [ADDR_WIDTH-1:0] ifd_addr,
  output logic                  ifd_done,
  output logic [DATA_WIDTH-1:0] ifd_rdata,
  input  logic                  ex_req,
  input  logic                  ex_we,
  input  logic [ADDR_WIDTH-1:0] ex_addr,
  input  logic [DATA_WIDTH-1:0] ex_wdata,
  output logic                  ex_done,
  output logic [DATA_WIDTH-1:0] ex_rdata,
  output logic                  mem_valid,
  output logic                  mem_we,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0] mem_wdata,
  input  logic                  mem_ready,
  input  logic [DATA_WIDTH-1:0] mem_rdata,
  output logic                  err
);

  typedef enum logic [1:0] {IDLE, IFD_ACC, EX_ACC, RESP} state_t;

  state_t state;
  logic   last_ex;

  if (TIMEOUT_CYCLES < 1) begin : g_bad_timeout
    $error("TIMEOUT_CYCLES must be at least 1");
  end

`ifdef PDP_MEM_ARB_TIMEOUT_EN
  localparam int WD_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [WD_W-1:0] wd_cnt;
  logic            err_q;
  assign err = err_q;
`else
  assign err = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      last_ex   <= 1'b1;
      mem_valid <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      ifd_done  <= 1'b0;
      ex_done   <= 1'b0;
      ifd_rdata <= '0;
      ex_rdata  <= '0;
`ifdef PDP_MEM_ARB_TIMEOUT_EN
      wd_cnt    <= '0;
      err_q     <= 1'b0;
`endif
    end else begin
      ifd_done <= 1'b0;
      ex_done  <= 1'b0;
`ifdef PDP_MEM_ARB_TIMEOUT_EN
      err_q    <= 1'b0;
`endif
      case (state)
        IDLE: begin
          // IFD wins when it is the only requester or when EX held the last grant
          if (ifd_req && (!ex_req || last_ex)) begin
            state     <= IFD_ACC;
            last_ex   <= 1'b0;
            mem_valid <= 1'b1;
            mem_we    <= 1'b0;
            mem_addr  <= ifd_addr;
            mem_wdata <= '0;
`ifdef PDP_MEM_ARB_TIMEOUT_EN
            wd_cnt    <= '0;
`endif
          end else if (ex_req) begin
            state     <= EX_ACC;
            last_ex   <= 1'b1;
            mem_valid <= 1'b1;
            mem_we    <= ex_we;
            mem_addr  <= ex_addr;
            mem_wdata <= ex_wdata;
`ifdef PDP_MEM_ARB_TIMEOUT_EN
            wd_cnt    <= '0;
`endif
          end
        end

        IFD_ACC, EX_ACC: begin
          if (mem_ready) begin
            state     <= RESP;
            mem_valid <= 1'b0;
            if (state == IFD_ACC) begin
              ifd_rdata <= mem_rdata;
              ifd_done  <= 1'b1;
            end else begin
              if (!mem_we) ex_rdata <= mem_rdata;
              ex_done <= 1'b1;
            end
          end
`ifdef PDP_MEM_ARB_TIMEOUT_EN
          // Watchdog expiry completes the access with err and leaves rdata untouched
          else if (wd_cnt == WD_W'(TIMEOUT_CYCLES - 1)) begin
            state     <= RESP;
            mem_valid <= 1'b0;
            err_q     <= 1'b1;
            if (state == IFD_ACC) ifd_done <= 1'b1;
            else                  ex_done  <= 1'b1;
          end else begin
            wd_cnt <= wd_cnt + 1'b1;
          end
`endif
        end

        RESP: state <= IDLE;

        default: state <= IDLE;
      endcase
    end
  end

endmodule
